// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell is time-shared over
// all bit positions, LSB first, with valid/ready handshakes on both sides.
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             busy
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q;
  logic             carry_q, out_co_q;

  logic fa_a, fa_b, fa_s, fa_co;

  // The single adder cell, fed from the operand shift-register LSBs.
  always_comb begin
    fa_a  = a_sr_q[0];
    fa_b  = b_sr_q[0];
    fa_s  = fa_a ^ fa_b ^ carry_q;
    fa_co = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      out_co_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: invert B up front, seed carry with 1.
            a_sr_q  <= in_a;
            b_sr_q  <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          sum_sr_q <= {fa_s, sum_sr_q[WIDTH-1:1]};
          carry_q  <= fa_co;
          if (cnt_q == LAST) begin
            cnt_q    <= '0;
            out_co_q <= fa_co;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_sr_q;
  assign out_co    = out_co_q;
endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Randomized bench for bit_serial_add_ctrl at WIDTH=8 and WIDTH=2, checked
// against an arithmetic reference {co,sum} = A + (sub ? ~B : B) + sub.
module tb_bit_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       sel = 1'b0;  // 0: WIDTH=8 instance, 1: WIDTH=2 instance

  logic       iv8, iv2;
  logic       ir8, ov8, co8, bz8;
  logic [7:0] sum8;
  logic       ir2, ov2, co2, bz2;
  logic [1:0] sum2;

  assign iv8 = in_valid & ~sel;
  assign iv2 = in_valid & sel;

  bit_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(ov8), .out_ready(out_ready), .out_sum(sum8),
    .out_co(co8), .busy(bz8));

  bit_serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_a(in_a[1:0]), .in_b(in_b[1:0]),
    .in_sub(in_sub), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
    .out_co(co2), .busy(bz2));

  logic       ir, ov, oco, obz;
  logic [7:0] osum;
  assign ir   = sel ? ir2 : ir8;
  assign ov   = sel ? ov2 : ov8;
  assign oco  = sel ? co2 : co8;
  assign obz  = sel ? bz2 : bz8;
  assign osum = sel ? {6'b0, sum2} : sum8;

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                       input logic sub);
    int mask, bw, t;
    logic [8:0] r;
    mask = (1 << w) - 1;
    bw   = sub ? (~int'(b) & mask) : (int'(b) & mask);
    t    = (int'(a) & mask) + bw + int'(sub);
    r    = '0;
    r[7:0] = 8'(t & mask);
    r[8]   = 1'((t >> w) & 1);
    return r;
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input int stall, input string tg);
    int k, w;
    logic [8:0] exp;
    w   = sel ? 2 : 8;
    exp = model(w, a, b, sub);
    @(negedge clk);
    k = 0;
    while (!ir && k < 50) begin @(negedge clk); k++; end
    chk({tg, " rdy"}, ir, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
    chk({tg, " busy"}, {obz, ir}, 2'b10);
    k = 0;
    while (!ov && k < 50) begin @(negedge clk); k++; end
    chk({tg, " lat"}, k, w);
    chk({tg, " sum"}, osum, exp[7:0]);
    chk({tg, " co"}, oco, exp[8]);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tg, " hold"}, {ov, ir, oco, osum}, {1'b1, 1'b0, exp[8], exp[7:0]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tg, " idle"}, {ov, ir}, 2'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, k;
    logic [7:0] fa, fb;
    logic fs, got, seen;
    logic [8:0] res;

    repeat (2) @(negedge clk);
    chk("reset8", {ir8, ov8, co8, bz8, sum8}, {4'b1000, 8'h00});
    chk("reset2", {ir2, ov2, co2, bz2, sum2}, {4'b1000, 2'b00});
    rst = 1'b0;

    do_op(8'hFF, 8'h01, 1'b0, 0, "ff+01");
    do_op(8'd5,  8'd3,  1'b1, 0, "5-3");
    do_op(8'd3,  8'd5,  1'b1, 0, "3-5");
    do_op(8'hA5, 8'h5A, 1'b0, 5, "a5+5a");

    // Operands change every cycle with in_valid held high.
    @(negedge clk);
    acc1 = -1; acc2 = -1; got = 1'b0; res = '0; fa = '0; fb = '0; fs = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
      if (ir) begin
        if (acc1 < 0) begin acc1 = cyc; fa = in_a; fb = in_b; fs = in_sub; end
        else if (acc2 < 0) acc2 = cyc;
      end
      @(negedge clk);
      if (ov && !got) begin got = 1'b1; res = {oco, osum}; end
    end
    in_valid = 1'b0;
    k = 0;
    while (!ir && k < 50) begin @(negedge clk); k++; end
    out_ready = 1'b0;
    chk("hold-valid got", got, 1);
    chk("hold-valid res", res, model(8, fa, fb, fs));
    chk("hold-valid spacing", acc2 - acc1, 10);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44; in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-rst state", {ir, ov, obz}, 3'b100);
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin @(negedge clk); if (ov) seen = 1'b1; end
    out_ready = 1'b0;
    chk("mid-rst no valid", seen, 0);
    do_op(8'h10, 8'h20, 1'b0, 0, "10+20");

    for (int i = 0; i < 1000; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd8");
    sel = 1'b1;
    do_op(8'h03, 8'h01, 1'b0, 0, "w2 3+1");
    do_op(8'h01, 8'h02, 1'b1, 0, "w2 1-2");
    for (int i = 0; i < 1000; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
